// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Operands are registered at grant; the result is held until the owner takes it.
//
// state | meaning
// IDLE  | waiting for a request; req_ready strobes the granted index
// EXEC  | registered operands drive the ALU for one cycle
// RESP  | result held on rsp_*, waiting for the owner's rsp_ready
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int IDX_W   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*CTRL_W-1:0]   req_ctrl,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [CTRL_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]           alu_out,
  input  logic                        alu_zero,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_zero,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] grant_oh;
  logic [DATA_W-1:0]  grant_a;
  logic [DATA_W-1:0]  grant_b;
  logic [CTRL_W-1:0]  grant_ctrl;
  logic               handshake;

  // Two passes: indices at or above rr_ptr first, then the wrapped-around ones.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    grant_a     = '0;
    grant_b     = '0;
    grant_ctrl  = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req_valid[i] &&
            ((IDX_W'(i) >= rr_ptr) == (pass == 0))) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(i);
          grant_oh[i] = 1'b1;
          grant_a     = req_a[i*DATA_W +: DATA_W];
          grant_b     = req_b[i*DATA_W +: DATA_W];
          grant_ctrl  = req_ctrl[i*CTRL_W +: CTRL_W];
        end
      end
    end
  end

  assign req_ready = (state == IDLE && !reset) ? grant_oh : '0;
  assign handshake = (state == RESP) && (|(rsp_valid & rsp_ready));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_a    <= grant_a;
            alu_b    <= grant_b;
            alu_ctrl <= grant_ctrl;
            owner    <= grant_idx;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= RESP;
        end
        RESP: begin
          if (handshake) begin
            rsp_valid <= '0;
            rr_ptr    <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
